alu_arbiter: RTL and testbench

Two-port arbiter sharing one ALU instance between two requesters, for example the integer pipe and an address/branch-compare unit. Each accepted request is evaluated on the shared ALU in its grant cycle. Its result is registered into that port's private response slot, which holds it until drained. Grants are round-robin, and a port whose response slot is still occupied is not granted.

---
 rtl/alu_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared ALU. Round-robin grants, and each
// port has a private registered response slot that must drain before it refills.

module alu_core (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Pure combinational ALU; shift amounts use b[4:0] only.
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {31'd0, (a < b)};
            default:  y = 32'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err
);
    function automatic logic op_defined(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    logic        ptr_r;
    logic        elig0_s, elig1_s;
    logic        gnt0_s, gnt1_s;
    logic [3:0]  alu_op_s;
    logic [31:0] alu_a_s, alu_b_s, alu_y_s;
    logic [31:0] cap_result_s;
    logic        cap_zero_s, cap_err_s;

    logic        rsp0_valid_r, rsp0_zero_r, rsp0_err_r;
    logic        rsp1_valid_r, rsp1_zero_r, rsp1_err_r;
    logic [31:0] rsp0_result_r, rsp1_result_r;

    // A slot that is draining this cycle can accept a refill at the same edge.
    always_comb begin
        elig0_s = req0_valid && (!rsp0_valid_r || rsp0_ready);
        elig1_s = req1_valid && (!rsp1_valid_r || rsp1_ready);
    end

    // Round-robin grant; ptr_r names the port that wins a tie.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (elig0_s && elig1_s) begin
            gnt0_s = (ptr_r == 1'b0);
            gnt1_s = (ptr_r == 1'b1);
        end else begin
            gnt0_s = elig0_s;
            gnt1_s = elig1_s;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Operand mux toward the shared ALU, with RV32 shift-amount masking.
    always_comb begin
        alu_op_s = req0_op;
        alu_a_s  = req0_a;
        alu_b_s  = req0_b;
        if (gnt1_s) begin
            alu_op_s = req1_op;
            alu_a_s  = req1_a;
            alu_b_s  = req1_b;
        end else begin
            alu_op_s = req0_op;
            alu_a_s  = req0_a;
            alu_b_s  = req0_b;
        end
        if (op_is_shift(alu_op_s)) begin
            alu_b_s = {27'd0, alu_b_s[4:0]};
        end else begin
            alu_b_s = alu_b_s;
        end
    end

    alu_core u_alu (
        .op (alu_op_s),
        .a  (alu_a_s),
        .b  (alu_b_s),
        .y  (alu_y_s)
    );

    // Undefined codes are decided here so the ALU's output for them never matters.
    always_comb begin
        cap_err_s    = !op_defined(alu_op_s);
        cap_result_s = 32'd0;
        if (cap_err_s) begin
            cap_result_s = 32'd0;
        end else begin
            cap_result_s = alu_y_s;
        end
        cap_zero_s = (cap_result_s == 32'd0);
    end

    // Priority pointer: the port just served yields the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= RR_INIT;
        end else if (gnt0_s) begin
            ptr_r <= 1'b1;
        end else if (gnt1_s) begin
            ptr_r <= 1'b0;
        end
    end

    // Port 0 response slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_r  <= 1'b0;
            rsp0_result_r <= 32'd0;
            rsp0_zero_r   <= 1'b0;
            rsp0_err_r    <= 1'b0;
        end else if (gnt0_s) begin
            rsp0_valid_r  <= 1'b1;
            rsp0_result_r <= cap_result_s;
            rsp0_zero_r   <= cap_zero_s;
            rsp0_err_r    <= cap_err_s;
        end else if (rsp0_ready) begin
            rsp0_valid_r  <= 1'b0;
        end
    end

    // Port 1 response slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid_r  <= 1'b0;
            rsp1_result_r <= 32'd0;
            rsp1_zero_r   <= 1'b0;
            rsp1_err_r    <= 1'b0;
        end else if (gnt1_s) begin
            rsp1_valid_r  <= 1'b1;
            rsp1_result_r <= cap_result_s;
            rsp1_zero_r   <= cap_zero_s;
            rsp1_err_r    <= cap_err_s;
        end else if (rsp1_ready) begin
            rsp1_valid_r  <= 1'b0;
        end
    end

    assign rsp0_valid  = rsp0_valid_r;
    assign rsp0_result = rsp0_result_r;
    assign rsp0_zero   = rsp0_zero_r;
    assign rsp0_err    = rsp0_err_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp1_zero   = rsp1_zero_r;
    assign rsp1_err    = rsp1_err_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed expectations.

module tb_alu_arbiter;
    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND_ = 4'd2;
    localparam logic [3:0] OR_  = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4;
    localparam logic [3:0] SLL  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] SLT  = 4'd8;
    localparam logic [3:0] SLTU = 4'd9;
    localparam logic [3:0] UNDF = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        #1;
        check({tag, "_rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
        check({tag, "_rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic check_rsp0(input string tag, input logic v, input logic [31:0] res, input logic z, input logic e);
        check({tag, "_v0"},   {31'd0, rsp0_valid}, {31'd0, v});
        check({tag, "_res0"}, rsp0_result, res);
        check({tag, "_z0"},   {31'd0, rsp0_zero}, {31'd0, z});
        check({tag, "_e0"},   {31'd0, rsp0_err}, {31'd0, e});
    endtask

    task automatic check_rsp1(input string tag, input logic v, input logic [31:0] res, input logic z, input logic e);
        check({tag, "_v1"},   {31'd0, rsp1_valid}, {31'd0, v});
        check({tag, "_res1"}, rsp1_result, res);
        check({tag, "_z1"},   {31'd0, rsp1_zero}, {31'd0, z});
        check({tag, "_e1"},   {31'd0, rsp1_err}, {31'd0, e});
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b1, ADD, 32'd1, 32'd1);
        drive1(1'b1, ADD, 32'd1, 32'd1);
        check_rdy("in_reset", 1'b0, 1'b0);
        step();
        step();
        check_rdy("reset_held", 1'b0, 1'b0);
        check_rsp0("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        check_rsp1("reset", 1'b0, 32'd0, 1'b0, 1'b0);

        // Single request on port 0; consumer not ready.
        rst = 1'b0;
        drive1(1'b0, ADD, 32'd0, 32'd0);
        drive0(1'b1, ADD, 32'd5, 32'd7);
        check_rdy("add_gnt", 1'b1, 1'b0);
        step();
        drive0(1'b0, ADD, 32'd0, 32'd0);
        check_rsp0("add", 1'b1, 32'd12, 1'b0, 1'b0);
        step();
        check_rsp0("add_hold", 1'b1, 32'd12, 1'b0, 1'b0);
        drive0(1'b1, SUB, 32'd9, 32'd1);
        check_rdy("slot_full", 1'b0, 1'b0);
        drive0(1'b0, ADD, 32'd0, 32'd0);
        rsp0_ready = 1'b1;
        step();
        check_rsp0("drain", 1'b0, 32'd12, 1'b0, 1'b0);

        // Both contend, consumers ready; pointer is 1 after the port 0 grant.
        rsp1_ready = 1'b1;
        drive0(1'b1, SUB, 32'd3, 32'd3);
        drive1(1'b1, SLT, 32'hFFFF_FFFF, 32'd1);
        check_rdy("alt_a", 1'b0, 1'b1);
        step();
        check_rsp1("slt", 1'b1, 32'd1, 1'b0, 1'b0);
        drive1(1'b1, SLTU, 32'hFFFF_FFFF, 32'd1);
        check_rdy("alt_b", 1'b1, 1'b0);
        step();
        check_rsp0("sub", 1'b1, 32'd0, 1'b1, 1'b0);
        drive0(1'b1, ADD, 32'd5, 32'd7);
        check_rdy("alt_c", 1'b0, 1'b1);
        step();
        check_rsp1("sltu", 1'b1, 32'd0, 1'b1, 1'b0);
        check_rdy("alt_d", 1'b1, 1'b0);
        step();
        check_rsp0("alt_add", 1'b1, 32'd12, 1'b0, 1'b0);

        // Port 0 slot stays full; port 1 wins every cycle.
        rsp0_ready = 1'b0;
        drive0(1'b1, OR_, 32'h0000_00F0, 32'h0000_000F);
        drive1(1'b1, AND_, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check_rdy("full_a", 1'b0, 1'b1);
        step();
        check_rsp1("and", 1'b1, 32'h0F00_0F00, 1'b0, 1'b0);
        drive1(1'b1, XOR_, 32'hAAAA_5555, 32'hFFFF_0000);
        check_rdy("full_b", 1'b0, 1'b1);
        step();
        check_rsp1("xor", 1'b1, 32'h5555_5555, 1'b0, 1'b0);
        check_rsp0("full_hold", 1'b1, 32'd12, 1'b0, 1'b0);
        rsp0_ready = 1'b1;
        check_rdy("refill", 1'b1, 1'b0);
        step();
        check_rsp0("or_refill", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);

        // Shifts and undefined op back to back on port 0 alone.
        drive1(1'b0, ADD, 32'd0, 32'd0);
        drive0(1'b1, SLL, 32'd1, 32'd33);
        check_rdy("sll", 1'b1, 1'b0);
        step();
        check_rsp0("sll", 1'b1, 32'd2, 1'b0, 1'b0);
        drive0(1'b1, SRA, 32'h8000_0000, 32'd4);
        check_rdy("sra", 1'b1, 1'b0);
        step();
        check_rsp0("sra", 1'b1, 32'hF800_0000, 1'b0, 1'b0);
        drive0(1'b1, SRL, 32'h8000_0000, 32'h0000_0024);
        check_rdy("srl", 1'b1, 1'b0);
        step();
        check_rsp0("srl", 1'b1, 32'h0800_0000, 1'b0, 1'b0);
        drive0(1'b1, UNDF, 32'd5, 32'd7);
        check_rdy("undf", 1'b1, 1'b0);
        step();
        check_rsp0("undf", 1'b1, 32'd0, 1'b1, 1'b1);
        drive0(1'b0, ADD, 32'd0, 32'd0);
        step();
        check_rsp0("idle_drain", 1'b0, 32'd0, 1'b1, 1'b1);

        // Reset right after a grant, before the consumer drains.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b1, ADD, 32'd5, 32'd7);
        check_rdy("pre_rst", 1'b1, 1'b0);
        step();
        check_rsp0("pre_rst", 1'b1, 32'd12, 1'b0, 1'b0);
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive1(1'b1, SUB, 32'd8, 32'd3);
        check_rdy("mid_rst", 1'b0, 1'b0);
        step();
        check_rsp0("post_rst", 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check_rdy("ptr_init", 1'b1, 1'b0);
        step();
        check_rsp0("ptr_init", 1'b1, 32'd12, 1'b0, 1'b0);
        check_rdy("after_init", 1'b0, 1'b1);
        step();
        check_rsp1("after_init", 1'b1, 32'd5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
